// File: rtl/fcr_cmd_arb_pkg.sv
// Shared types and constants for the two-source command/response arbiter.
// Defines the FSM state encodings, the source indices and the data widths.
package fcr_cmd_arb_pkg;

    typedef enum logic [1:0] {
        A_IDLE  = 2'd0,
        A_FETCH = 2'd1,
        A_OFFER = 2'd2,
        A_EXEC  = 2'd3
    } arb_state_e;

    localparam logic SRC_HOST = 1'b0;
    localparam logic SRC_SEQ  = 1'b1;

    localparam int CMD_W = 32;
    localparam int CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fcr_cmd_arb_if.sv
// Command/response bus between the two upstream FIFO pairs, the arbiter and the controller.
// master = arbiter view, slave = surrounding FIFOs and controller.
interface fcr_cmd_arb_if;
    import fcr_cmd_arb_pkg::*;

    // Handshake: a command word moves when *_cmd_waitreq is low and *_cmd_rdreq is high in
    // the same cycle; a response word moves on *_rsp_wrreq while *_rsp_waitreq is low.
    logic [CMD_W-1:0] src0_cmd_data,  src1_cmd_data;
    logic             src0_cmd_waitreq, src1_cmd_waitreq;
    logic             src0_cmd_rdreq, src1_cmd_rdreq;
    logic [CMD_W-1:0] src0_rsp_data,  src1_rsp_data;
    logic             src0_rsp_wrreq, src1_rsp_wrreq;
    logic             src0_rsp_waitreq, src1_rsp_waitreq;
    logic [CMD_W-1:0] dn_cmd_data;
    logic             dn_cmd_waitreq;
    logic             dn_cmd_rdreq;
    logic [CMD_W-1:0] dn_rsp_data;
    logic             dn_rsp_wrreq;
    logic             dn_rsp_waitreq;

    modport master (
        input  src0_cmd_data, src1_cmd_data, src0_cmd_waitreq, src1_cmd_waitreq,
        output src0_cmd_rdreq, src1_cmd_rdreq,
        output src0_rsp_data, src1_rsp_data, src0_rsp_wrreq, src1_rsp_wrreq,
        input  src0_rsp_waitreq, src1_rsp_waitreq,
        output dn_cmd_data, dn_cmd_waitreq,
        input  dn_cmd_rdreq, dn_rsp_data, dn_rsp_wrreq,
        output dn_rsp_waitreq
    );

    modport slave (
        output src0_cmd_data, src1_cmd_data, src0_cmd_waitreq, src1_cmd_waitreq,
        input  src0_cmd_rdreq, src1_cmd_rdreq,
        input  src0_rsp_data, src1_rsp_data, src0_rsp_wrreq, src1_rsp_wrreq,
        output src0_rsp_waitreq, src1_rsp_waitreq,
        input  dn_cmd_data, dn_cmd_waitreq,
        output dn_cmd_rdreq, dn_rsp_data, dn_rsp_wrreq,
        input  dn_rsp_waitreq
    );

endinterface

// File: rtl/fcr_cmd_arb_rr_arb2.sv
// Combinational two-request round-robin picker.
// A sole requester wins; on a tie the source that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       any
);

    always_comb begin
        any    = |req;
        winner = (&req) ? ~last : req[1];
    end

endmodule

// File: rtl/fcr_cmd_arb.sv
// Two-source command arbiter: grants one source, holds its command word for the controller
// and routes the controller's response back to the granted source only.
module fcr_cmd_arb
    import fcr_cmd_arb_pkg::*;
#(
    parameter int               TMO_W       = 16,
    parameter logic [TMO_W-1:0] RSP_TIMEOUT = {TMO_W{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    fcr_cmd_arb_if.master    bus,
    output logic             grant,
    output logic             busy,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             stray_rsp,
    output arb_state_e       state_dbg
);

    arb_state_e       state;
    logic             last_grant;
    logic [CMD_W-1:0] cmd_hold;
    logic [TMO_W-1:0] timer;
    logic             src0_rdreq_r;
    logic             src1_rdreq_r;
    logic             dn_cmd_waitreq_r;
    logic             winner;
    logic             any;
    logic             in_exec;
    logic             rsp_fire;

    rr_arb2 u_pick (
        .req    ({~bus.src1_cmd_waitreq, ~bus.src0_cmd_waitreq}),
        .last   (last_grant),
        .winner (winner),
        .any    (any)
    );

    assign in_exec  = (state == A_EXEC);
    assign rsp_fire = in_exec & bus.dn_rsp_wrreq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= A_IDLE;
            grant            <= SRC_HOST;
            last_grant       <= SRC_SEQ;
            cmd_hold         <= '0;
            timer            <= '0;
            drop_cnt         <= '0;
            stray_rsp        <= 1'b0;
            src0_rdreq_r     <= 1'b0;
            src1_rdreq_r     <= 1'b0;
            dn_cmd_waitreq_r <= 1'b1;
            busy             <= 1'b0;
        end else begin
            if (bus.dn_rsp_wrreq && !in_exec) stray_rsp <= 1'b1;
            src0_rdreq_r <= 1'b0;
            src1_rdreq_r <= 1'b0;
            case (state)
                A_IDLE: begin
                    if (any) begin
                        state        <= A_FETCH;
                        grant        <= winner;
                        busy         <= 1'b1;
                        src0_rdreq_r <= (winner == SRC_HOST);
                        src1_rdreq_r <= (winner == SRC_SEQ);
                    end
                end
                A_FETCH: begin
                    // Showahead FIFO: the word being popped this cycle is already on the data bus.
                    cmd_hold         <= (grant == SRC_SEQ) ? bus.src1_cmd_data : bus.src0_cmd_data;
                    state            <= A_OFFER;
                    dn_cmd_waitreq_r <= 1'b0;
                end
                A_OFFER: begin
                    if (bus.dn_cmd_rdreq) begin
                        state            <= A_EXEC;
                        timer            <= '0;
                        dn_cmd_waitreq_r <= 1'b1;
                    end
                end
                A_EXEC: begin
                    // A response on the timeout cycle wins over the drop.
                    if (bus.dn_rsp_wrreq) begin
                        state      <= A_IDLE;
                        last_grant <= grant;
                        busy       <= 1'b0;
                    end else if (timer == RSP_TIMEOUT - 1'b1) begin
                        state      <= A_IDLE;
                        last_grant <= grant;
                        busy       <= 1'b0;
                        drop_cnt   <= sat_inc(drop_cnt);
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state            <= A_IDLE;
                    busy             <= 1'b0;
                    dn_cmd_waitreq_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.src0_cmd_rdreq = src0_rdreq_r;
    assign bus.src1_cmd_rdreq = src1_rdreq_r;
    assign bus.dn_cmd_data    = cmd_hold;
    assign bus.dn_cmd_waitreq = dn_cmd_waitreq_r;
    assign bus.dn_rsp_waitreq = in_exec ? ((grant == SRC_SEQ) ? bus.src1_rsp_waitreq
                                                              : bus.src0_rsp_waitreq)
                                        : 1'b1;
    assign bus.src0_rsp_wrreq = rsp_fire & (grant == SRC_HOST);
    assign bus.src1_rsp_wrreq = rsp_fire & (grant == SRC_SEQ);
    assign bus.src0_rsp_data  = bus.dn_rsp_data;
    assign bus.src1_rsp_data  = bus.dn_rsp_data;
    assign state_dbg          = state;

endmodule
